// File: rtl/ws2812_stream_decoder.sv
// ws2812_stream_decoder
// Receive-side WS2812 decoder: classifies high pulses by width, assembles
// 24-bit pixels (first bit in pixel[0]), counts pixels per frame and flags
// frame ends, glitches, stuck-high lines and partial pixels at the latch.
module ws2812_stream_decoder #(
    parameter int THRESH       = 25,
    parameter int MIN_HIGH     = 6,
    parameter int MAX_HIGH     = 60,
    parameter int RESET_CYCLES = 1000,
    parameter int CW           = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        datastream,
    output logic [23:0] pixel,
    output logic        pixel_valid,
    output logic [8:0]  pixel_index,
    output logic        frame_done,
    output logic [8:0]  frame_pixels,
    output logic        error,
    output logic [1:0]  err_type
);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_HIGH);
    localparam logic [CW-1:0] STUCK_C  = CW'(MAX_HIGH + 1);
    localparam logic [CW-1:0] RESET_C  = CW'(RESET_CYCLES);

    state_t        state;
    state_t        next_state;

    logic          ds_m;
    logic          ds_s;
    logic          ds_q;
    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;

    logic [23:0]   shreg;
    logic [4:0]    bitcnt;
    logic [8:0]    pixcnt;
    logic          pix_pend;

    logic          glitch_ev;
    logic          stuck_ev;
    logic          bit_ev;
    logic          bit_val;
    logic          frame_ev;

    assign rise = ds_s & ~ds_q;
    assign fall = ~ds_s & ds_q;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ds_m <= 1'b0;
            ds_s <= 1'b0;
            ds_q <= 1'b0;
        end else begin
            ds_m <= datastream;
            ds_s <= ds_m;
            ds_q <= ds_s;
        end
    end

    // Width counter: the edge cycle itself is the first cycle of the new
    // level, so it loads 1 and the value seen at the opposite edge equals
    // the number of cycles the level lasted. Saturates at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (rise || fall) begin
            cnt <= CW'(1);
        end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + CW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SYNC;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and single-cycle decode events.
    always_comb begin
        next_state = state;
        glitch_ev  = 1'b0;
        stuck_ev   = 1'b0;
        bit_ev     = 1'b0;
        bit_val    = 1'b0;
        frame_ev   = 1'b0;
        case (state)
            SYNC: begin
                // On the fall cycle cnt still holds the high width, so it
                // must not be mistaken for a long low period.
                if (!ds_s && !fall && cnt >= RESET_C) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    next_state = HIGH;
                end
            end
            HIGH: begin
                if (cnt == STUCK_C) begin
                    stuck_ev   = 1'b1;
                    next_state = SYNC;
                end else if (fall) begin
                    next_state = LOW;
                    if (cnt < MIN_C) begin
                        glitch_ev = 1'b1;
                    end else begin
                        bit_ev  = 1'b1;
                        bit_val = (cnt >= THRESH_C);
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    next_state = HIGH;
                end else if (!ds_s && cnt >= RESET_C) begin
                    frame_ev   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = SYNC;
            end
        endcase
    end

    // Bit assembly, pixel/frame bookkeeping and registered output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg        <= '0;
            bitcnt       <= '0;
            pixcnt       <= '0;
            pix_pend     <= 1'b0;
            pixel        <= '0;
            pixel_valid  <= 1'b0;
            pixel_index  <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            error        <= 1'b0;
            err_type     <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            pix_pend    <= bit_ev && (bitcnt == 5'd23);

            if (bit_ev) begin
                shreg  <= {bit_val, shreg[23:1]};
                bitcnt <= bitcnt + 5'd1;
            end

            // One cycle after the 24th bit lands, publish the word.
            if (pix_pend) begin
                pixel       <= shreg;
                pixel_valid <= 1'b1;
                pixel_index <= pixcnt;
                bitcnt      <= '0;
                if (pixcnt != 9'd511) begin
                    pixcnt <= pixcnt + 9'd1;
                end
            end

            if (glitch_ev) begin
                error    <= 1'b1;
                err_type <= 2'b01;
            end

            // A stuck line loses alignment, so the whole frame is dropped.
            if (stuck_ev) begin
                error    <= 1'b1;
                err_type <= 2'b10;
                shreg    <= '0;
                bitcnt   <= '0;
                pixcnt   <= '0;
            end

            if (frame_ev) begin
                frame_done   <= 1'b1;
                frame_pixels <= pixcnt;
                pixcnt       <= '0;
                bitcnt       <= '0;
                shreg        <= '0;
                if (bitcnt != 5'd0) begin
                    error    <= 1'b1;
                    err_type <= 2'b11;
                end
            end
        end
    end

endmodule

// File: doc/ws2812_stream_decoder.md
Name: ws2812_stream_decoder

Overview:
Receive-side counterpart of the WS2812B single-wire encoder. The block samples a WS2812-style `datastream` on the 40 MHz system clock and classifies each high pulse as a 0 or 1 by its width. It assembles the bits into 24-bit pixel words, counts pixels, and flags frame ends on the latch (reset) low period. It is used for loopback checking of the LED driver and for daisy-chain monitoring on the FPGA.

Parameters:
THRESH, 25, high width (cycles) at or above which a bit decodes as 1; below it the bit decodes as 0.
MIN_HIGH, 6, high pulses shorter than this are glitches.
MAX_HIGH, 60, high pulses longer than this are stuck-line errors.
RESET_CYCLES, 1000, continuous low cycles that end a frame (25 us).
CW, 12, width of the pulse-width counter; must satisfy 2^CW > RESET_CYCLES.

Ports:
clk  in  1  system clock, 40 MHz
reset  in  1  asynchronous, active-low reset (0 = reset)
datastream  in  1  asynchronous serial LED data line
pixel  out  24  last completed pixel; first received bit in pixel[0]
pixel_valid  out  1  one-cycle pulse, pixel and pixel_index valid
pixel_index  out  9  0-based index of the pixel within the frame, saturates at 511
frame_done  out  1  one-cycle pulse at end of frame
frame_pixels  out  9  count of complete pixels in the ended frame; valid with frame_done
error  out  1  one-cycle pulse
err_type  out  2  valid with error: 01 glitch, 10 stuck high, 11 partial pixel at latch

Behaviour:
- Reset (reset=0, async): all outputs 0; state SYNC; counters and shift register cleared; synchronizer flops 0.
- Input path: 2-flop synchronizer gives ds_s; ds_q is ds_s delayed one cycle. Rise = ds_s & ~ds_q. Fall = ~ds_s & ds_q.
- Width counter: clears on every edge, increments otherwise, saturates at 2^CW-1. The measured high width equals the number of cycles ds_s was 1.
- SYNC: wait until ds_s has been low for RESET_CYCLES consecutive cycles, then go to IDLE. Any rise restarts the count. This prevents mid-frame alignment after reset or an error.
- IDLE: line low, frame open with 0 pixels. On rise, go to HIGH.
- HIGH: on fall, classify width w:
  - w < MIN_HIGH: error pulse, err_type=01, bit discarded, go to LOW.
  - otherwise: bit = (w >= THRESH); shift in with shreg <= {bit, shreg[23:1]}; bitcnt++; go to LOW.
  - If the counter reaches MAX_HIGH+1 while still high: error pulse, err_type=10, discard partial bits, skip frame_done, go to SYNC.
- On the 24th valid bit:
  - Next cycle: pixel=shreg (post-shift), pixel_valid=1, pixel_index=current pixel count.
  - Then the pixel count increments (saturating at 511) and bitcnt is set to 0.
- LOW: on rise, go to HIGH. When the low count reaches RESET_CYCLES:
  - frame_done=1 and frame_pixels=pixel count.
  - If bitcnt≠0, error with err_type=11 in the same cycle, and the partial bits are discarded.
  - Clear pixel count and bitcnt; go to IDLE.
- IDLE never generates frame_done, so repeated latch periods produce no pulses.
- Latency: pixel_valid rises 3 clk edges after the edge that first samples datastream low at the end of the 24th bit (2 sync + 1 register).
- pixel and pixel_index hold their values until the next pixel_valid. frame_pixels holds until the next frame_done.
- Simultaneous events: bit 24 completing and a glitch cannot coincide, since glitches never count. Frame end takes priority over nothing else because it only occurs in LOW.
- Reset mid-frame: immediate abort; no frame_done or error is emitted.

Test Plan:
- Settle 1000 low cycles. Drive one pixel 24'h00b000 LSB-first with 17-cycle highs for 0 and 33-cycle highs for 1, lows of 35/19 cycles, then 2001 low cycles -> pixel_valid once with pixel=24'h00b000 and pixel_index=0; frame_done with frame_pixels=1; no error.
- Drive three pixels 24'h00f060, 24'h0000b0, 24'hb05000, then latch -> three pixel_valid pulses with index 0,1,2 and matching data; frame_done with frame_pixels=3.
- Insert a 3-cycle high between bits 5 and 6 of 24'h00b0b0 -> error with err_type=01; the pixel still decodes to 24'h00b0b0.
- Hold datastream high for 100 cycles mid-pixel -> error with err_type=10 at high count 61. Following bits are ignored until 1000 low cycles; a subsequent pixel decodes with index 0.
- Send 10 bits, then 1000 low cycles -> error with err_type=11 and frame_done with frame_pixels=0 in the same cycle; no pixel_valid.
- Assert reset low for 1 cycle mid-pixel -> all outputs 0 immediately. Pixels are ignored until 1000 low cycles have passed.
